// File: rtl/quad_pkg.sv
// Shared types and constants for the quadrature decoder.
package quad_pkg;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_TRACK = 1'b1
    } state_e;

    // Forward sequence on {A,B}: 00 -> 10 -> 11 -> 01 -> 00
    localparam logic [1:0] AB_S0 = 2'b00;
    localparam logic [1:0] AB_S1 = 2'b10;
    localparam logic [1:0] AB_S2 = 2'b11;
    localparam logic [1:0] AB_S3 = 2'b01;

    localparam int                   ERR_CNT_W   = 8;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'd255;

    // Next {A,B} value when moving one step forward from ab.
    function automatic logic [1:0] fwd_next(input logic [1:0] ab);
        case (ab)
            AB_S0:   return AB_S1;
            AB_S1:   return AB_S2;
            AB_S2:   return AB_S3;
            default: return AB_S0;
        endcase
    endfunction

endpackage

// File: rtl/quad_filter.sv
// Two-flop synchronizer followed by a stability filter. A value is qualified
// once the synchronized input has held it for FILT_LEN consecutive cycles;
// the qualified value and a one-cycle valid pulse leave through an output
// register so the decoder sees a clean, aligned pair.
module quad_filter #(
    parameter int FILT_LEN = 4,
    parameter int W        = 2
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         dout_vld
);

    localparam int             CW    = $clog2(FILT_LEN + 1);
    localparam logic [CW-1:0]  LEN_C = CW'(FILT_LEN);

    logic [W-1:0]  sync1_q, sync1_d;
    logic [W-1:0]  sync2_q, sync2_d;
    logic [W-1:0]  cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  filt_q, filt_d;
    logic          hit_q, hit_d;
    logic [W-1:0]  out_q, out_d;
    logic          vld_q, vld_d;
    logic          changed;

    // Next-state: synchronizer shift, candidate tracking, count and qualify.
    always_comb begin
        sync1_d = din;
        sync2_d = sync1_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        filt_d  = filt_q;
        hit_d   = 1'b0;
        changed = (sync2_q != cand_q);
        if (changed) begin
            cand_d = sync2_q;
            cnt_d  = CW'(1);
        end else if (cnt_q != LEN_C) begin
            cnt_d = cnt_q + CW'(1);
        end
        // Qualify only on the cycle the count first reaches FILT_LEN.
        if ((cnt_d == LEN_C) && (changed || (cnt_q != LEN_C))) begin
            filt_d = cand_d;
            hit_d  = 1'b1;
        end
        out_d = filt_q;
        vld_d = hit_q;
    end

    // State registers; reset drops any partially filtered value.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_q <= '0;
            sync2_q <= '0;
            cand_q  <= '0;
            cnt_q   <= '0;
            filt_q  <= '0;
            hit_q   <= 1'b0;
            out_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            filt_q  <= filt_d;
            hit_q   <= hit_d;
            out_q   <= out_d;
            vld_q   <= vld_d;
        end
    end

    assign dout     = out_q;
    assign dout_vld = vld_q;

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: filtered A/B edges become step/updown pulses for an
// external counter; two-bit jumps are flagged as errors and counted.
module quad_decoder
    import quad_pkg::*;
#(
    parameter int FILT_LEN = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 enable,
    input  logic                 a_in,
    input  logic                 b_in,
    input  logic                 err_clr,
    output logic                 step,
    output logic                 updown,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    logic [1:0]           filt_ab;
    logic                 filt_vld;
    state_e               state_q, state_d;
    logic [1:0]           prev_ab_q, prev_ab_d;
    logic                 step_q, step_d;
    logic                 updown_q, updown_d;
    logic                 err_q, err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [1:0]           diff;

    quad_filter #(
        .FILT_LEN (FILT_LEN),
        .W        (2)
    ) u_filter (
        .clk      (clk),
        .rstn     (rstn),
        .din      ({a_in, b_in}),
        .dout     (filt_ab),
        .dout_vld (filt_vld)
    );

    // Next-state and outputs; clear is applied first so a same-cycle error lands on a zero base.
    always_comb begin
        state_d   = state_q;
        prev_ab_d = prev_ab_q;
        step_d    = 1'b0;
        updown_d  = updown_q;
        err_d     = err_clr ? 1'b0 : err_q;
        err_cnt_d = err_clr ? '0 : err_cnt_q;
        diff      = filt_ab ^ prev_ab_q;
        case (state_q)
            ST_INIT: begin
                if (filt_vld) begin
                    prev_ab_d = filt_ab;
                    state_d   = ST_TRACK;
                end
            end
            ST_TRACK: begin
                if (filt_vld) begin
                    prev_ab_d = filt_ab;
                    if (enable) begin
                        if (diff == 2'b11) begin
                            err_d = 1'b1;
                            if (err_cnt_d != ERR_CNT_MAX) begin
                                err_cnt_d = err_cnt_d + 1'b1;
                            end
                        end else if (diff != 2'b00) begin
                            step_d   = 1'b1;
                            updown_d = (fwd_next(prev_ab_q) == filt_ab);
                        end
                    end
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_INIT;
            prev_ab_q <= 2'b00;
            step_q    <= 1'b0;
            updown_q  <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            prev_ab_q <= prev_ab_d;
            step_q    <= step_d;
            updown_q  <= updown_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign step    = step_q;
    assign updown  = updown_q;
    assign err     = err_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder with FILT_LEN = 4.
module tb_quad_decoder;

    localparam int FILT_LEN = 4;
    localparam int LAT      = FILT_LEN + 3;

    logic       clk;
    logic       rstn;
    logic       enable;
    logic       a_in;
    logic       b_in;
    logic       err_clr;
    logic       step;
    logic       updown;
    logic       err;
    logic [7:0] err_cnt;

    int         checks = 0;
    int         errors = 0;
    int         step_total = 0;
    logic [7:0] pos = 8'd0;
    int         s0;

    quad_decoder #(.FILT_LEN(FILT_LEN)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .enable  (enable),
        .a_in    (a_in),
        .b_in    (b_in),
        .err_clr (err_clr),
        .step    (step),
        .updown  (updown),
        .err     (err),
        .err_cnt (err_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // External up/down counter model fed by step/updown.
    always @(posedge clk) begin
        if (rstn && step) begin
            step_total = step_total + 1;
            pos = updown ? pos + 8'd1 : pos - 8'd1;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive_ab(input logic [1:0] ab);
        a_in = ab[1];
        b_in = ab[0];
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Legal edge: expect one step of the given direction, LAT cycles later, one cycle wide.
    task automatic move(input logic [1:0] ab, input int exp_dir, input string tag);
        int lat;
        lat = -1;
        drive_ab(ab);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (step === 1'b1 && lat < 0) begin
                lat = k - 1;
                chk({tag, " dir"}, int'(updown), exp_dir);
            end else if (lat >= 0 && k == lat + 2) begin
                chk({tag, " width"}, int'(step), 0);
            end
        end
        chk({tag, " lat"}, lat, LAT);
        chk({tag, " hold"}, int'(updown), exp_dir);
    endtask

    initial begin
        rstn    = 1'b0;
        enable  = 1'b1;
        err_clr = 1'b0;
        drive_ab(2'b00);
        idle(3);
        chk("rst step", int'(step), 0);
        chk("rst updown", int'(updown), 0);
        chk("rst err", int'(err), 0);
        chk("rst err_cnt", int'(err_cnt), 0);
        rstn = 1'b1;

        // Constant 00 after reset: INIT load only, never a step.
        s0 = step_total;
        idle(20);
        chk("idle00 steps", step_total - s0, 0);
        chk("idle00 err", int'(err), 0);

        // Forward cycle.
        pos = 8'd0;
        s0  = step_total;
        move(2'b10, 1, "fwd1");
        move(2'b11, 1, "fwd2");
        move(2'b01, 1, "fwd3");
        move(2'b00, 1, "fwd4");
        chk("fwd steps", step_total - s0, 4);
        chk("fwd pos", int'(pos), 4);

        // Reverse cycle from a zeroed counter.
        pos = 8'd0;
        s0  = step_total;
        move(2'b01, 0, "rev1");
        move(2'b11, 0, "rev2");
        move(2'b10, 0, "rev3");
        move(2'b00, 0, "rev4");
        chk("rev steps", step_total - s0, 4);
        chk("rev pos", int'(pos), 252);

        // Illegal two-bit jump.
        s0 = step_total;
        drive_ab(2'b11);
        idle(20);
        chk("ill steps", step_total - s0, 0);
        chk("ill err", int'(err), 1);
        chk("ill err_cnt", int'(err_cnt), 1);

        // 300 more illegal toggles saturate the count.
        for (int i = 0; i < 300; i++) begin
            drive_ab((i % 2 == 0) ? 2'b00 : 2'b11);
            idle(6);
        end
        idle(10);
        chk("sat err_cnt", int'(err_cnt), 255);
        chk("sat err", int'(err), 1);
        chk("sat steps", step_total - s0, 0);

        // Clear coinciding with an illegal edge (11 -> 00).
        drive_ab(2'b00);
        idle(7);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("clr+ill err", int'(err), 1);
        chk("clr+ill err_cnt", int'(err_cnt), 1);
        idle(12);

        // Clear alone.
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("clr err", int'(err), 0);
        chk("clr err_cnt", int'(err_cnt), 0);

        // Two-cycle glitch on A.
        s0 = step_total;
        a_in = 1'b1;
        idle(2);
        a_in = 1'b0;
        idle(20);
        chk("glitch steps", step_total - s0, 0);
        chk("glitch err", int'(err), 0);

        // Disabled over two legal edges, then re-enabled.
        enable = 1'b0;
        drive_ab(2'b10);
        idle(20);
        drive_ab(2'b11);
        idle(20);
        enable = 1'b1;
        idle(20);
        chk("dis steps", step_total - s0, 0);
        chk("dis err", int'(err), 0);
        move(2'b01, 1, "reen");

        // Reset shortly after an input change abandons the edge.
        drive_ab(2'b00);
        idle(2);
        rstn = 1'b0;
        #1;
        chk("midrst step", int'(step), 0);
        chk("midrst updown", int'(updown), 0);
        idle(2);
        chk("midrst err_cnt", int'(err_cnt), 0);
        rstn = 1'b1;
        s0 = step_total;
        idle(30);
        chk("postrst steps", step_total - s0, 0);
        chk("postrst err", int'(err), 0);
        move(2'b10, 1, "postrst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
